keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad on the board I/O header and reports key presses to the core.
- Drives one column low at a time, samples the four row inputs, debounces whole-keypad frames, and emits press events through a valid/ready handshake.
- Input-side counterpart of the multiplexed display driver; it shares the same active-low one-hot select scheme on the board pins.

Parameters:
SCAN_DIV, 1000, clk cycles each column is driven before its rows are sampled (≥2)
DEBOUNCE_CNT, 4, consecutive identical frames required to commit a new key state (1..15)

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
ROWIN  input  4  keypad rows, active-low (pulled up), asynchronous to clk
COLSEL  output  4  column drive, active-low one-hot
key_code  output  4  press event code = row*4 + col
key_valid  output  1  key_code holds an unconsumed press event
key_ready  input  1  consumer accepts event when key_valid && key_ready
key_held  output  16  debounced level state, bit (row*4+col) = 1 while pressed
key_drop  output  1  one-cycle pulse: press event lost because output slot was occupied

Behaviour:
- Reset (rst low, asynchronous): COLSEL=4'b1110, column index 0, dwell counter 0, key_code=0, key_valid=0, key_held=0, key_drop=0, frame/prev-frame/stable-count=0, synchronizer flops=4'b1111.
- ROWIN passes through a 2-flop synchronizer before any use.
- Dwell counter runs 0..SCAN_DIV-1 per column.
  - On count SCAN_DIV-1: the inverted synchronized rows are written into frame bits [r*4+col], the column index increments mod 4, and COLSEL rotates (1110→1101→1011→0111→1110).
  - Sampling at end of dwell gives ≥SCAN_DIV-2 cycles of settling after synchronizer delay.
- Frame completes when column 3 is sampled; frame period = 4*SCAN_DIV cycles.
- Debounce, evaluated at frame completion:
  - If frame != prev_frame: stable count = 1.
  - Otherwise: stable count increments, saturating at 15.
  - prev_frame <= frame.
  - When stable count == DEBOUNCE_CNT after this update and frame != key_held: commit.
  - With DEBOUNCE_CNT=1, every frame commits.
- Commit: new = frame & ~key_held; key_held <= frame.
  - If new != 0, the event code is the lowest set bit index of new. Other simultaneously new bits are not reported as events; they still appear in key_held.
- Releases update key_held only; they generate no event.
- Output slot, on a commit with an event:
  - key_valid=0: load key_code, set key_valid.
  - key_valid=1 and key_ready=1 in the same cycle: load the new code, key_valid stays 1.
  - key_valid=1 and key_ready=0: the old event is kept, the new one is discarded, and key_drop pulses for 1 cycle.
- Without an event commit, key_valid clears on key_valid && key_ready. key_code holds its last value.
- Mid-operation reset: immediate return to reset state. Any partially built frame is discarded.

Optional Feature:
KEYPAD_GHOST_REJECT_EN
- Defined: a completed frame with 3 or more bits set (possible ghosting) is invalid. It sets stable count to 0, leaves prev_frame unchanged, and blocks commit. key_held and the event path are unaffected until a valid frame arrives.
- Undefined: all frames are processed as above, with no population count logic.

Decomposition:
- board_pkg holds:
  - KEY_ROWS=4 and KEY_COLS=4
  - typedef key_code_t (4-bit)
  - typedef key_map_t (16-bit)
  - COLSEL reset constant 4'b1110, shared with the display mux select encoding
- One natural sub-module: sync_2ff (parameterised width, async active-low reset to a given value), instanced for ROWIN.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=2, frame=16 cycles):
- Reset then idle, rows 4'b1111 → COLSEL cycles 1110,1101,1011,0111 every 4 clk; key_valid=0; key_held=0.
- Row 2 held low only while COLSEL=1101 (key r2c1), stable for 3 frames → key_held=16'h0200 after the 2nd identical frame; key_valid=1, key_code=9; valid held until key_ready=1 pulse, then drops next cycle.
- Bounce: key r0c0 toggled every frame for 4 frames, then steady → no event during toggling; key_code=0 exactly 2 frames after steady.
- key_valid=1 with key_ready=0 and second key r3c3 committed → key_code keeps old value, key_drop=1 for one cycle, key_held includes bit 15.
- Keys r0c0 and r1c1 pressed together → single event key_code=0, key_held=16'h0021. Release → key_held=0 after 2 frames, no event.
- With KEYPAD_GHOST_REJECT_EN: r0c0, r0c1, r1c0 pressed → no commit, key_held unchanged. Without the macro → key_held=16'h0013, event key_code=0.

Source files
------------

// File: rtl/board_pkg.sv
// Board-level I/O constants and helpers for the keypad header.
//
// Contents:
//   KEY_ROWS / KEY_COLS / KEY_NUM : keypad matrix geometry (4x4)
//   key_code_t : 4-bit key index, row*4 + col
//   key_map_t  : 16-bit key bitmap, bit (row*4 + col)
//   SEL_RESET  : reset value of an active-low one-hot select bus. The
//                multiplexed display driver uses the same encoding, so a
//                column/digit select starts on index 0 in both blocks.
//   place_column() : merge one column of active-low row samples into a frame
//   lowest_set()   : index of the lowest set bit of a key map
package board_pkg;

  localparam int KEY_ROWS = 4;
  localparam int KEY_COLS = 4;
  localparam int KEY_NUM  = KEY_ROWS * KEY_COLS;

  typedef logic [3:0]         key_code_t;
  typedef logic [KEY_NUM-1:0] key_map_t;

  localparam logic [KEY_COLS-1:0] SEL_RESET = 4'b1110;

  // Rows are pulled up and read low when pressed, so invert on the way in.
  function automatic key_map_t place_column(input key_map_t            f,
                                            input logic [1:0]          col,
                                            input logic [KEY_ROWS-1:0] rows_n);
    key_map_t m;
    m = f;
    for (int r = 0; r < KEY_ROWS; r++)
      m[r*KEY_COLS + int'(col)] = ~rows_n[r];
    return m;
  endfunction

  // Scan from the top down so the last hit is the lowest index.
  function automatic key_code_t lowest_set(input key_map_t m);
    key_code_t c;
    c = '0;
    for (int i = KEY_NUM-1; i >= 0; i--)
      if (m[i]) c = key_code_t'(i);
    return c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
//
// Parameters:
//   WIDTH   : number of independent bits
//   RST_VAL : value both stages take during reset
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
//
// Bits are synchronized independently. Callers must not rely on
// multi-bit coherency in the same cycle.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame debounce and a one-deep event slot.
//
// One column at a time is driven low on COLSEL. Each column is held for
// SCAN_DIV cycles, and the synchronized rows are sampled on the last cycle.
// Four columns make one frame. A frame must repeat DEBOUNCE_CNT times before
// it becomes the new key_held level map. On such a commit, the lowest newly
// pressed key is offered on key_code/key_valid. Releases only update
// key_held.
//
// Parameters:
//   SCAN_DIV     : clk cycles per column dwell (>= 2)
//   DEBOUNCE_CNT : identical frames needed to commit (1..15)
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   ROWIN     : keypad rows, active-low, asynchronous
//   COLSEL    : column drive, active-low one-hot
//   key_code  : press event code, row*4 + col
//   key_valid : key_code holds an unconsumed event
//   key_ready : consumer accept, taken when key_valid && key_ready
//   key_held  : debounced key map
//   key_drop  : one-cycle pulse when an event is lost because the slot is full
//
// Optional build macro:
//   KEYPAD_GHOST_REJECT_EN : a frame with three or more keys set may be a
//   matrix ghost. Such a frame resets the stable count, leaves prev_frame
//   unchanged, and never commits.
module keypad_scan
  import board_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_ROWS-1:0] ROWIN,
  output logic [KEY_COLS-1:0] COLSEL,
  output key_code_t           key_code,
  output logic                key_valid,
  input  logic                key_ready,
  output key_map_t            key_held,
  output logic                key_drop
);

  localparam int             DW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     STABLE_MAX  = 4'd15;
  localparam logic [3:0]     STABLE_GOAL = 4'(DEBOUNCE_CNT);

  logic [KEY_ROWS-1:0] rows_s;
  logic [DW-1:0]       dwell;
  logic [1:0]          col;
  key_map_t            frame;
  key_map_t            prev_frame;
  logic [3:0]          stable;

  logic                dwell_end;
  logic                frame_done;
  logic                frame_bad;
  key_map_t            frame_nxt;
  key_map_t            new_keys;
  logic [3:0]          stable_nxt;
  logic                commit;
  logic                evt;
  key_code_t           evt_code;
  logic                slot_load;

  sync_2ff #(
    .WIDTH   (KEY_ROWS),
    .RST_VAL ({KEY_ROWS{1'b1}})
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (ROWIN),
    .q     (rows_s)
  );

  // The column-3 sample is merged combinationally, so the debounce logic
  // sees the finished frame on the same edge that samples it.
  always_comb begin
    dwell_end  = (dwell == DWELL_LAST);
    frame_nxt  = place_column(frame, col, rows_s);
    frame_done = dwell_end && (col == 2'd3);
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  // With one column driven at a time, three keys on a rectangle corner can
  // show the fourth key as phantom-pressed. Any frame of three or more keys
  // is treated as untrustworthy.
  logic [4:0] frame_pop;

  always_comb begin
    frame_pop = '0;
    for (int i = 0; i < KEY_NUM; i++)
      frame_pop = frame_pop + 5'(frame_nxt[i]);
  end

  assign frame_bad = (frame_pop >= 5'd3);
`else
  assign frame_bad = 1'b0;
`endif

  always_comb begin
    stable_nxt = stable;
    if (frame_bad)
      stable_nxt = '0;
    else if (frame_nxt != prev_frame)
      stable_nxt = 4'd1;
    else if (stable != STABLE_MAX)
      stable_nxt = stable + 4'd1;

    // A commit happens only when the count reaches the goal on this frame.
    // A frame that stays stable longer does not re-commit.
    commit    = frame_done && !frame_bad && (stable_nxt == STABLE_GOAL)
                && (frame_nxt != key_held);
    new_keys  = frame_nxt & ~key_held;
    evt       = commit && (new_keys != '0);
    evt_code  = lowest_set(new_keys);
    // The slot takes a new event if it is empty, or if it is being drained
    // on this same edge.
    slot_load = evt && (!key_valid || key_ready);
  end

  // Scan timing and column drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell  <= '0;
      col    <= '0;
      COLSEL <= SEL_RESET;
      frame  <= '0;
    end else if (dwell_end) begin
      dwell  <= '0;
      col    <= col + 2'd1;
      COLSEL <= {COLSEL[KEY_COLS-2:0], COLSEL[KEY_COLS-1]};
      frame  <= frame_nxt;
    end else begin
      dwell  <= dwell + DW'(1);
    end
  end

  // Debounce state and the debounced key map.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_frame <= '0;
      stable     <= '0;
      key_held   <= '0;
    end else if (frame_done) begin
      stable <= stable_nxt;
      if (!frame_bad) prev_frame <= frame_nxt;
      if (commit)     key_held   <= frame_nxt;
    end
  end

  // Event slot. key_code keeps its last value after the event is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      key_drop  <= 1'b0;
    end else begin
      key_drop <= evt && key_valid && !key_ready;
      if (slot_load) begin
        key_code  <= evt_code;
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=4 and DEBOUNCE_CNT=2 (16-cycle frames).
// The keypad is modelled as a pressed-key map that pulls rows low for the
// driven column. Expected press codes are queued when keys are applied. A
// monitor pops the queue whenever a new event appears on key_valid.
module tb_keypad_scan;
  import board_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      ROWIN;
  logic [3:0]      COLSEL;
  key_code_t       key_code;
  logic            key_valid;
  logic            key_ready;
  key_map_t        key_held;
  logic            key_drop;

  key_map_t        pressed;
  logic [3:0]      expq[$];
  int              checks    = 0;
  int              errors    = 0;
  int              drops_seen = 0;
  int              exp_drops  = 0;
  logic            seen      = 1'b0;

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ROWIN     (ROWIN),
    .COLSEL    (COLSEL),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_held  (key_held),
    .key_drop  (key_drop)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    ROWIN = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!COLSEL[c] && pressed[r*4 + c]) ROWIN[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Return just after the edge where COLSEL wraps back to 1110 (frame done).
  task automatic wait_frame();
    logic [3:0] last;
    bit         found;
    last  = COLSEL;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (COLSEL == 4'b1110 && last != 4'b1110) found = 1'b1;
      last = COLSEL;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout actual=%0h required=%0h", COLSEL, 4'b1110);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) wait_frame();
  endtask

  task automatic pulse_ready();
    key_ready = 1'b1;
    @(posedge clk); #1;
    key_ready = 1'b0;
  endtask

  // Monitor: compare each newly presented event against the queue and count
  // drop pulses.
  always @(negedge clk) begin
    if (!rst) begin
      seen = 1'b0;
    end else begin
      if (key_valid && !seen) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event actual=%0h required=none", key_code);
        end else begin
          logic [3:0] e;
          e = expq.pop_front();
          if (key_code !== e) begin
            errors++;
            $display("FAIL event_code actual=%0h required=%0h", key_code, e);
          end
        end
        seen = 1'b1;
      end
      if (key_valid && key_ready) seen = 1'b0;
      if (key_drop) drops_seen++;
    end
  end

  initial begin
    logic [3:0] sel_seq [5];
    sel_seq[0] = 4'b1110; sel_seq[1] = 4'b1101; sel_seq[2] = 4'b1011;
    sel_seq[3] = 4'b0111; sel_seq[4] = 4'b1110;

    rst = 1'b0; pressed = '0; key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_colsel", 32'(COLSEL),    32'hE);
    check("rst_valid",  32'(key_valid), 32'h0);
    check("rst_held",   32'(key_held),  32'h0);
    check("rst_code",   32'(key_code),  32'h0);
    check("rst_drop",   32'(key_drop),  32'h0);
    @(negedge clk) rst = 1'b1;

    // Idle: the column drive rotates every 4 cycles.
    for (int k = 0; k < 5; k++) begin
      check($sformatf("idle_colsel%0d", k), 32'(COLSEL), 32'(sel_seq[k]));
      repeat (4) @(posedge clk);
      #1;
    end
    check("idle_valid", 32'(key_valid), 32'h0);
    check("idle_held",  32'(key_held),  32'h0);
    frames(1);

    // Press r2c1, which commits after the second identical frame.
    pressed = 16'h0200; expq.push_back(4'd9);
    frames(1);
    check("r2c1_held_f1", 32'(key_held), 32'h0);
    frames(1);
    check("r2c1_held_f2", 32'(key_held),  32'h0200);
    check("r2c1_valid",   32'(key_valid), 32'h1);
    repeat (5) @(posedge clk);
    #1;
    check("r2c1_valid_hold", 32'(key_valid), 32'h1);
    pulse_ready();
    check("r2c1_consumed", 32'(key_valid), 32'h0);
    frames(1);
    pressed = '0;
    frames(2);
    check("r2c1_release", 32'(key_held), 32'h0);

    // Bounce: r0c0 toggles every frame, so nothing commits.
    for (int i = 0; i < 4; i++) begin
      pressed = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      frames(1);
    end
    check("bounce_valid", 32'(key_valid), 32'h0);
    check("bounce_held",  32'(key_held),  32'h0);
    pressed = 16'h0001; expq.push_back(4'd0);
    frames(1);
    check("steady_f1_valid", 32'(key_valid), 32'h0);
    frames(1);
    check("steady_f2_valid", 32'(key_valid), 32'h1);
    check("steady_held",     32'(key_held),  32'h0001);

    // Slot still full when r3c3 commits: the new event is dropped.
    pressed = 16'h8001; exp_drops++;
    frames(2);
    check("drop_code",  32'(key_code),  32'h0);
    check("drop_held",  32'(key_held),  32'h8001);
    check("drop_valid", 32'(key_valid), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("drop_pulses", 32'(drops_seen), 32'(exp_drops));
    check("drop_low",    32'(key_drop),   32'h0);
    pulse_ready();
    check("drop_consumed", 32'(key_valid), 32'h0);
    frames(1);
    pressed = '0;
    frames(2);
    check("drop_release", 32'(key_held), 32'h0);

    // Two keys together: one event, lowest index.
    pressed = 16'h0021; expq.push_back(4'd0);
    frames(2);
    check("pair_held", 32'(key_held), 32'h0021);
    pulse_ready();
    check("pair_consumed", 32'(key_valid), 32'h0);
    frames(1);
    pressed = '0;
    frames(2);
    check("pair_release",       32'(key_held),  32'h0);
    check("pair_release_valid", 32'(key_valid), 32'h0);

    // Three keys forming a rectangle corner.
    pressed = 16'h0013;
`ifdef KEYPAD_GHOST_REJECT_EN
    frames(3);
    check("ghost_held",  32'(key_held),  32'h0);
    check("ghost_valid", 32'(key_valid), 32'h0);
`else
    expq.push_back(4'd0);
    frames(2);
    check("triple_held", 32'(key_held), 32'h0013);
    pulse_ready();
`endif
    frames(1);
    pressed = '0;
    frames(2);
    check("triple_release", 32'(key_held), 32'h0);

    // Reset mid-frame returns everything to the reset state.
    pressed = 16'h0200; expq.push_back(4'd9);
    frames(2);
    check("pre_rst_held", 32'(key_held), 32'h0200);
    pulse_ready();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_colsel", 32'(COLSEL),    32'hE);
    check("mid_rst_held",   32'(key_held),  32'h0);
    check("mid_rst_valid",  32'(key_valid), 32'h0);
    check("mid_rst_code",   32'(key_code),  32'h0);
    pressed = '0;
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_col0", 32'(COLSEL), 32'hE);
    @(posedge clk); #1;
    check("post_rst_col1", 32'(COLSEL), 32'hD);

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", 32'(expq.size()), 32'h0);
    check("drops_total", 32'(drops_seen),  32'(exp_drops));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
